flip_flop_d_checker: RTL and testbench

Synthesizable self-checking response monitor for a single-type D flip-flop (or a WIDTH-bit bank of them). It sits on the same clock as the DUT, watches the D input driven by the stimulus side and the Q output returned by the DUT, and checks each cycle that Q equals D delayed by exactly one rising edge. It reports a mismatch count, first-failure details, and a pass/done verdict after SAMPLES checks.

---
 rtl/flip_flop_d_checker_pkg.sv | 10 +
 rtl/flip_flop_d_checker_capture.sv | 38 +++
 rtl/flip_flop_d_checker.sv | 95 +++++++++
 tb/tb_flip_flop_d_checker.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/flip_flop_d_checker_pkg.sv
// flip_flop_d_checker_pkg: shared state encoding and counter width default for the D flip-flop checker
//   exports state_t (IDLE, CHECK, DONE) and CNT_W_DEF
package flip_flop_d_checker_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      DONE  = 2'd2
   } state_t;
   localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/flip_flop_d_checker_capture.sv
// flip_flop_d_checker_capture: first-failure record (index, expected, got), loaded once per run
//   clk, reset_L : clock, asynchronous active-low reset
//   clear        : synchronous zeroing of the record
//   load         : first mismatch seen this run
//   index/expected/got : values to record; fail_* : recorded values
module flip_flop_d_checker_capture
   import flip_flop_d_checker_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] index,
   input  logic [WIDTH-1:0] expected,
   input  logic [WIDTH-1:0] got,
   output logic [CNT_W-1:0] fail_index,
   output logic [WIDTH-1:0] fail_expected,
   output logic [WIDTH-1:0] fail_got
);
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         fail_index    <= '0;
         fail_expected <= '0;
         fail_got      <= '0;
      end else if (clear) begin
         fail_index    <= '0;
         fail_expected <= '0;
         fail_got      <= '0;
      end else if (load) begin
         fail_index    <= index;
         fail_expected <= expected;
         fail_got      <= got;
      end
   end
endmodule

// File: rtl/flip_flop_d_checker.sv
// flip_flop_d_checker: checks that Q_obs equals D_obs delayed by one rising edge, over SAMPLES compares
//   clk, reset_L  : clock shared with the DUT, asynchronous active-low reset
//   enable, clear : run checking / synchronous clear of verdict and statistics (clear wins)
//   D_obs, Q_obs  : D presented to the DUT, Q returned by it
//   done, pass, error, sample_count, mismatch_count : verdict and statistics
//   first_fail_index/expected/got : details of the first mismatch
module flip_flop_d_checker
   import flip_flop_d_checker_pkg::*;
#(
   parameter int WIDTH   = 1,
   parameter int SAMPLES = 16,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             enable,
   input  logic             clear,
   input  logic [WIDTH-1:0] D_obs,
   input  logic [WIDTH-1:0] Q_obs,
   output logic             done,
   output logic             pass,
   output logic             error,
   output logic [CNT_W-1:0] sample_count,
   output logic [CNT_W-1:0] mismatch_count,
   output logic [CNT_W-1:0] first_fail_index,
   output logic [WIDTH-1:0] first_fail_expected,
   output logic [WIDTH-1:0] first_fail_got
);
   if (SAMPLES < 1 || 2.0 ** CNT_W <= SAMPLES) begin : g_bad_params
      $error("flip_flop_d_checker: need SAMPLES >= 1 and 2**CNT_W > SAMPLES");
   end

   state_t           state, state_nxt;
   logic [WIDTH-1:0] exp_q;
   logic             cmp, mis, last;

   // a compare only happens on an enabled CHECK edge that is not being cleared
   assign cmp  = state == CHECK && enable && !clear;
   assign mis  = cmp && Q_obs != exp_q;
   assign last = sample_count == CNT_W'(SAMPLES - 1);

   always_comb begin
      state_nxt = state;
      if (clear)
         state_nxt = IDLE;
      else if (state == IDLE)
         state_nxt = enable ? CHECK : IDLE;
      else if (state == CHECK)
         state_nxt = !enable ? IDLE : last ? DONE : CHECK;
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state          <= IDLE;
         exp_q          <= '0;
         sample_count   <= '0;
         mismatch_count <= '0;
         error          <= 1'b0;
      end else begin
         state <= state_nxt;
         if (clear) begin
            exp_q          <= '0;
            sample_count   <= '0;
            mismatch_count <= '0;
            error          <= 1'b0;
         end else begin
            // priming and every compare both load the next expectation
            if ((state == IDLE && enable) || cmp)
               exp_q <= D_obs;
            if (cmp)
               sample_count <= sample_count + 1'b1;
            if (mis) begin
               mismatch_count <= mismatch_count + 1'b1;
               error          <= 1'b1;
            end
         end
      end
   end

   assign done = state == DONE;
   assign pass = done && mismatch_count == '0;

   flip_flop_d_checker_capture #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_capture (
      .clk           (clk),
      .reset_L       (reset_L),
      .clear         (clear),
      .load          (mis && !error),
      .index         (sample_count),
      .expected      (exp_q),
      .got           (Q_obs),
      .fail_index    (first_fail_index),
      .fail_expected (first_fail_expected),
      .fail_got      (first_fail_got)
   );
endmodule

// File: tb/tb_flip_flop_d_checker.sv
// tb_flip_flop_d_checker: directed self-checking bench for flip_flop_d_checker (WIDTH=1, SAMPLES=4)
module tb_flip_flop_d_checker;
   logic       clk = 1'b0;
   logic       reset_L = 1'b0;
   logic       enable = 1'b0;
   logic       clear = 1'b0;
   logic [0:0] D_obs = '0;
   logic [0:0] Q_obs = '0;
   logic       done, pass, error;
   logic [7:0] sample_count, mismatch_count, first_fail_index;
   logic [0:0] first_fail_expected, first_fail_got;
   int         checks = 0;
   int         errors = 0;

   flip_flop_d_checker #(.WIDTH(1), .SAMPLES(4), .CNT_W(8)) dut (
      .clk                 (clk),
      .reset_L             (reset_L),
      .enable              (enable),
      .clear               (clear),
      .D_obs               (D_obs),
      .Q_obs               (Q_obs),
      .done                (done),
      .pass                (pass),
      .error               (error),
      .sample_count        (sample_count),
      .mismatch_count      (mismatch_count),
      .first_fail_index    (first_fail_index),
      .first_fail_expected (first_fail_expected),
      .first_fail_got      (first_fail_got)
   );

   always #5 clk = ~clk;

   // {done, pass, error, sample_count, mismatch_count, first_fail_index, first_fail_expected, first_fail_got}
   function automatic logic [28:0] obs();
      return {done, pass, error, sample_count, mismatch_count, first_fail_index,
              first_fail_expected, first_fail_got};
   endfunction

   function automatic logic [28:0] vec(input logic d, input logic p, input logic e, input int sc,
                                       input int mc, input int fi, input logic fe, input logic fg);
      return {d, p, e, 8'(sc), 8'(mc), 8'(fi), fe, fg};
   endfunction

   task automatic step(input logic en, input logic cl, input logic d, input logic q);
      @(negedge clk);
      enable = en;
      clear  = cl;
      D_obs  = d;
      Q_obs  = q;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [28:0] want;
      reset_L = 1'b0;
      step(1, 0, 1, 0);
      step(1, 0, 0, 1);
      want = '0;
      checks++;
      if (obs() !== want) begin
         errors++;
         $display("FAIL reset_hold got=%h want=%h", obs(), want);
      end
      @(negedge clk);
      enable  = 1'b0;
      reset_L = 1'b1;
      step(0, 0, 1, 0);
      checks++;
      if (obs() !== want) begin
         errors++;
         $display("FAIL reset_release_idle got=%h want=%h", obs(), want);
      end
   endtask

   task automatic test_ideal();
      logic [28:0] want;
      step(1, 0, 1, 0);
      step(1, 0, 0, 1);
      step(1, 0, 0, 0);
      step(1, 0, 1, 0);
      want = vec(0, 0, 0, 3, 0, 0, 0, 0);
      checks++;
      if (obs() !== want) begin
         errors++;
         $display("FAIL ideal_not_done_yet got=%h want=%h", obs(), want);
      end
      step(1, 0, 1, 1);
      want = vec(1, 1, 0, 4, 0, 0, 0, 0);
      checks++;
      if (obs() !== want) begin
         errors++;
         $display("FAIL ideal_done got=%h want=%h", obs(), want);
      end
   endtask

   task automatic test_stuck_at_0();
      logic [28:0] want;
      step(0, 1, 0, 0);
      checks++;
      if (obs() !== '0) begin
         errors++;
         $display("FAIL stuck_clear got=%h want=0", obs());
      end
      step(1, 0, 1, 0);
      want = '0;
      checks++;
      if (obs() !== want) begin
         errors++;
         $display("FAIL stuck_prime got=%h want=%h", obs(), want);
      end
      step(1, 0, 1, 0);
      want = vec(0, 0, 1, 1, 1, 0, 1, 0);
      checks++;
      if (obs() !== want) begin
         errors++;
         $display("FAIL stuck_first_error got=%h want=%h", obs(), want);
      end
      step(1, 0, 0, 0);
      step(1, 0, 1, 0);
      step(1, 0, 0, 0);
      want = vec(1, 0, 1, 4, 3, 0, 1, 0);
      checks++;
      if (obs() !== want) begin
         errors++;
         $display("FAIL stuck_done got=%h want=%h", obs(), want);
      end
   endtask

   task automatic test_pause();
      logic [28:0] want;
      step(0, 1, 0, 0);
      step(1, 0, 1, 0);
      step(1, 0, 0, 1);
      step(1, 0, 1, 0);
      step(0, 0, 0, 0);
      step(0, 0, 1, 1);
      step(0, 0, 0, 1);
      want = vec(0, 0, 0, 2, 0, 0, 0, 0);
      checks++;
      if (obs() !== want) begin
         errors++;
         $display("FAIL pause_hold got=%h want=%h", obs(), want);
      end
      step(1, 0, 0, 1);
      checks++;
      if (obs() !== want) begin
         errors++;
         $display("FAIL pause_reprime got=%h want=%h", obs(), want);
      end
      step(1, 0, 1, 0);
      step(1, 0, 0, 1);
      want = vec(1, 1, 0, 4, 0, 0, 0, 0);
      checks++;
      if (obs() !== want) begin
         errors++;
         $display("FAIL pause_done got=%h want=%h", obs(), want);
      end
   endtask

   task automatic test_clear_in_done();
      logic [28:0] want;
      step(1, 0, 1, 0);
      want = vec(1, 1, 0, 4, 0, 0, 0, 0);
      checks++;
      if (obs() !== want) begin
         errors++;
         $display("FAIL done_frozen got=%h want=%h", obs(), want);
      end
      step(1, 1, 1, 0);
      checks++;
      if (obs() !== '0) begin
         errors++;
         $display("FAIL clear_with_enable got=%h want=0", obs());
      end
      step(1, 0, 1, 0);
      checks++;
      if (obs() !== '0) begin
         errors++;
         $display("FAIL clear_then_prime got=%h want=0", obs());
      end
      step(1, 0, 0, 1);
      want = vec(0, 0, 0, 1, 0, 0, 0, 0);
      checks++;
      if (obs() !== want) begin
         errors++;
         $display("FAIL clear_then_compare got=%h want=%h", obs(), want);
      end
   endtask

   task automatic test_async_reset();
      logic [28:0] want;
      step(1, 0, 1, 1);
      want = vec(0, 0, 1, 2, 1, 1, 0, 1);
      checks++;
      if (obs() !== want) begin
         errors++;
         $display("FAIL async_pre_error got=%h want=%h", obs(), want);
      end
      #1;
      reset_L = 1'b0;
      #1;
      checks++;
      if (obs() !== '0 || clk !== 1'b1) begin
         errors++;
         $display("FAIL async_reset_immediate got=%h want=0", obs());
      end
      #1;
      reset_L = 1'b1;
      step(1, 0, 1, 0);
      checks++;
      if (obs() !== '0) begin
         errors++;
         $display("FAIL async_reprime got=%h want=0", obs());
      end
      step(1, 0, 0, 1);
      want = vec(0, 0, 0, 1, 0, 0, 0, 0);
      checks++;
      if (obs() !== want) begin
         errors++;
         $display("FAIL async_compare got=%h want=%h", obs(), want);
      end
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_stuck_at_0();
      test_pause();
      test_clear_in_done();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
